// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes per clock into a working register.
// Optional macro INV_SUB_BYTES_ITER_PIPE_EN adds a register stage after the inverse S-boxes.
module inv_sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state
);

  localparam int N_SLICES = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam int SLICE_W  = 8 * BYTES_PER_CYCLE;
  localparam logic [0:127] SLICE_MASK = ~({128{1'b1}} >> SLICE_W);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{b, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               last_slice;
  logic [0:127]       work, work_nxt, out_q;
  logic [0:127]       rd_shift, wr_ext;
  logic [0:SLICE_W-1] rd_slice, sub_p0;
  logic [0:SLICE_W-1] wr_data;
  logic [CNT_W-1:0]   wr_idx;
  logic               wr_en, wr_last;

  assign last_slice = (cnt == CNT_W'(N_SLICES - 1));

  // p0: slice k of the working register through the replicated inverse S-boxes
  assign rd_shift = work << (int'(cnt) * SLICE_W);
  assign rd_slice = rd_shift[0:SLICE_W-1];

  for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
    assign sub_p0[8*b +: 8] = inv_sbox(rd_slice[8*b +: 8]);
  end

`ifdef INV_SUB_BYTES_ITER_PIPE_EN
  localparam state_t AFTER_LAST = DRAIN;

  logic [0:SLICE_W-1] sub_p1;
  logic [CNT_W-1:0]   idx_p1;
  logic               vld_p1;

  // p1: registered S-box outputs; the last slice lands during DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      sub_p1 <= '0;
      idx_p1 <= '0;
    end else begin
      vld_p1 <= (state == BUSY);
      if (state == BUSY) begin
        sub_p1 <= sub_p0;
        idx_p1 <= cnt;
      end
    end
  end

  assign wr_data = sub_p1;
  assign wr_idx  = idx_p1;
  assign wr_en   = vld_p1;
  assign wr_last = (state == DRAIN);
`else
  localparam state_t AFTER_LAST = DONE;

  assign wr_data = sub_p0;
  assign wr_idx  = cnt;
  assign wr_en   = (state == BUSY);
  assign wr_last = (state == BUSY) && last_slice;
`endif

  assign wr_ext = 128'(wr_data) << (128 - SLICE_W);

  always_comb begin
    work_nxt = (work & ~(SLICE_MASK >> (int'(wr_idx) * SLICE_W))) |
               (wr_ext >> (int'(wr_idx) * SLICE_W));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last_slice) state_nxt = AFTER_LAST;
      DRAIN:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // out_q only loads with a completed result, so partial values never reach out_state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        work <= in_state;
        cnt  <= '0;
      end else begin
        if (wr_en) work <= work_nxt;
        if (state == BUSY && !last_slice) cnt <= cnt + 1'b1;
      end
      if (wr_last) out_q <= work_nxt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_state = out_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Scoreboard bench for inv_sub_bytes_iter: five instances (1/2/4/8/16 bytes per cycle) checked
// against an inverse S-box derived from GF(2^8) inversion plus the affine map.
module tb_inv_sub_bytes_iter;

`ifdef INV_SUB_BYTES_ITER_PIPE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int NCFG = 5;
  localparam int D    = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid_s  [NCFG];
  logic         in_ready_s  [NCFG];
  logic [0:127] in_state_s  [NCFG];
  logic         out_valid_s [NCFG];
  logic         out_ready_s [NCFG];
  logic [0:127] out_state_s [NCFG];

  int           cyc = 0;
  int           acc_cyc [NCFG];
  logic [0:127] last_out [NCFG];
  logic [0:127] sb_q [$];
  logic [7:0]   inv_tab [256];
  int           n_checks = 0;
  int           n_pass = 0;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1 << g)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_s[g]), .in_ready(in_ready_s[g]), .in_state(in_state_s[g]),
      .out_valid(out_valid_s[g]), .out_ready(out_ready_s[g]), .out_state(out_state_s[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_tab();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [0:127] model(input logic [0:127] st);
    logic [0:127] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[st[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[8*(4*c + w) +: 8] = s[8*(4*((c - w + 4) % 4) + w) +: 8];
    return r;
  endfunction

  task automatic send(input int c, input logic [0:127] st, input logic [0:127] exp);
    int n;
    n = 0;
    in_state_s[c] = st;
    in_valid_s[c] = 1'b1;
    while (!in_ready_s[c] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept", 128'(in_ready_s[c]), 128'd1);
    @(posedge clk);
    #1;
    acc_cyc[c]    = cyc;
    in_valid_s[c] = 1'b0;
    in_state_s[c] = {$urandom, $urandom, $urandom, $urandom};
    sb_q.push_back(exp);
  endtask

  task automatic recv(input int c);
    int n;
    logic [0:127] e;
    n = 0;
    @(negedge clk);
    while (!out_valid_s[c] && n < 40) begin
      check_eq("hold", out_state_s[c], last_out[c]);
      @(negedge clk);
      n++;
    end
    check_eq("valid", 128'(out_valid_s[c]), 128'd1);
    check_eq("latency", 128'(cyc - acc_cyc[c]), 128'((16 >> c) + EXTRA));
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 128'd0, 128'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("data", out_state_s[c], e);
      last_out[c] = e;
    end
  endtask

  task automatic xfer(input int c, input logic [0:127] st, input logic [0:127] exp);
    send(c, st, exp);
    recv(c);
    @(negedge clk);
    check_eq("ret_ready", 128'(in_ready_s[c]), 128'd1);
    check_eq("ret_valid", 128'(out_valid_s[c]), 128'd0);
  endtask

  initial begin
    logic [0:127] a, b, st;
    build_tab();
    for (int c = 0; c < NCFG; c++) begin
      in_valid_s[c]  = 1'b0;
      out_ready_s[c] = 1'b1;
      in_state_s[c]  = '0;
      last_out[c]    = '0;
      acc_cyc[c]     = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < NCFG; c++) begin
      check_eq("rst_ready", 128'(in_ready_s[c]), 128'd1);
      check_eq("rst_valid", 128'(out_valid_s[c]), 128'd0);
      check_eq("rst_state", out_state_s[c], 128'd0);
    end

    xfer(D, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f);
    xfer(D, 128'h0, {16{8'h52}});
    xfer(D, {16{8'hff}}, {16{8'h7d}});
    xfer(D, inv_shift_rows(128'h7ad5fda789ef4e272bca100b3d9ff59f),
         128'hbd6e7c3df2b5779e0b61216e8b10b689);

    // backpressure: result held, second block refused until the result is taken
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    out_ready_s[D] = 1'b0;
    send(D, a, model(a));
    recv(D);
    in_state_s[D] = b;
    in_valid_s[D] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 128'(out_valid_s[D]), 128'd1);
      check_eq("bp_state", out_state_s[D], model(a));
      check_eq("bp_ready", 128'(in_ready_s[D]), 128'd0);
    end
    out_ready_s[D] = 1'b1;
    send(D, b, model(b));
    recv(D);
    @(negedge clk);

    // asynchronous reset two cycles into BUSY discards the block
    st = {$urandom, $urandom, $urandom, $urandom};
    send(D, st, model(st));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 128'(out_valid_s[D]), 128'd0);
    check_eq("mid_rst_state", out_state_s[D], 128'd0);
    check_eq("mid_rst_ready", 128'(in_ready_s[D]), 128'd1);
    void'(sb_q.pop_back());
    for (int c = 0; c < NCFG; c++) last_out[c] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    st = {$urandom, $urandom, $urandom, $urandom};
    xfer(D, st, model(st));

    for (int c = 0; c < NCFG; c++) begin
      for (int i = 0; i < 1000; i++) begin
        st = {$urandom, $urandom, $urandom, $urandom};
        xfer(c, st, model(st));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
